// File: rtl/fifo_cmd_player.sv
// -----------------------------------------------------------------------------
// fifo_cmd_player
//
// Consumer on the read side of the RFSoC command FIFO. Each FIFO word is
// {hold count, sample}. The sample is replayed on Sample_out for count+1
// consecutive cycles. One command is prefetched into a pending slot so that
// back-to-back commands of three or more cycles play with no gap.
//
// Ports:
//   Clk              single clock for the whole block
//   Clear_in         synchronous, active-high reset
//   Run_in           level enable for fetching and starting commands
//   Fifo_Data_in     FIFO read data, valid the cycle after a pop
//   Fifo_Empty_in    FIFO empty flag
//   Fifo_ReadEn_out  FIFO pop request
//   Sample_out       current sample, 0 when not valid
//   Valid_out        Sample_out carries a played sample this cycle
//   Busy_out         a command is playing, pending or in flight
//   Underflow_out    sticky: FIFO ran dry at the end of a command while running
//   CmdCount_out     commands started since Clear_in (wraps)
// -----------------------------------------------------------------------------
module fifo_cmd_player #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int COUNT_WIDTH  = 16,
    parameter int DATA_WIDTH   = SAMPLE_WIDTH + COUNT_WIDTH
) (
    input  logic                    Clk,
    input  logic                    Clear_in,
    input  logic                    Run_in,
    input  logic [DATA_WIDTH-1:0]   Fifo_Data_in,
    input  logic                    Fifo_Empty_in,
    output logic                    Fifo_ReadEn_out,
    output logic [SAMPLE_WIDTH-1:0] Sample_out,
    output logic                    Valid_out,
    output logic                    Busy_out,
    output logic                    Underflow_out,
    output logic [31:0]             CmdCount_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Player state
    state_t                  r_state;
    state_t                  w_state_next;
    logic [COUNT_WIDTH-1:0]  r_rem;
    logic [COUNT_WIDTH-1:0]  w_rem_next;
    logic [SAMPLE_WIDTH-1:0] r_sample;
    logic [SAMPLE_WIDTH-1:0] w_sample_next;

    // Prefetch path
    logic                    r_inflight;
    logic                    r_pend_valid;
    logic [DATA_WIDTH-1:0]   r_pend_data;

    logic                    r_underflow;
    logic [31:0]             r_cmd_count;

    logic                    w_cmd_end;
    logic                    w_load;
    logic                    w_pop;
    logic                    w_capture;
    logic                    w_underflow_evt;

    // Last cycle of the command currently being played.
    assign w_cmd_end = (r_state == ST_PLAY) && (r_rem == '0);

    // Start the pending command when the player is free at this edge.
    assign w_load = r_pend_valid && Run_in && ((r_state == ST_IDLE) || w_cmd_end);

    // Pop only when the pending slot is empty after this edge, so a capture
    // never lands on an occupied slot. Clear_in masks the request so no word
    // is lost from the FIFO while the block is being reset.
    assign w_pop = Run_in && !Fifo_Empty_in && !r_inflight &&
                   (!r_pend_valid || w_load) && !Clear_in;

    // One-cycle read latency: an in-flight word is on Fifo_Data_in now.
    assign w_capture = r_inflight;

    // FIFO ran dry exactly when a command ends while running.
    assign w_underflow_evt = w_cmd_end && Run_in && !r_pend_valid &&
                             !r_inflight && Fifo_Empty_in;

    // ---------------------------------------------------------------------
    // Player next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_rem_next    = r_rem;
        w_sample_next = r_sample;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_next  = ST_PLAY;
                    w_rem_next    = r_pend_data[DATA_WIDTH-1:SAMPLE_WIDTH];
                    w_sample_next = r_pend_data[SAMPLE_WIDTH-1:0];
                end
            end
            ST_PLAY: begin
                if (w_load) begin
                    // Back-to-back: next command starts with no bubble.
                    w_rem_next    = r_pend_data[DATA_WIDTH-1:SAMPLE_WIDTH];
                    w_sample_next = r_pend_data[SAMPLE_WIDTH-1:0];
                end else if (r_rem == '0) begin
                    w_state_next  = ST_IDLE;
                end else begin
                    w_rem_next    = r_rem - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_sample <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rem    <= w_rem_next;
            r_sample <= w_sample_next;
        end
    end

    // ---------------------------------------------------------------------
    // Prefetch, counters and flags
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            r_inflight   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_underflow  <= 1'b0;
            r_cmd_count  <= '0;
        end else begin
            // A pop requires no word in flight, so the flag is just the pop.
            r_inflight <= w_pop;

            if (w_capture) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= Fifo_Data_in;
            end else if (w_load) begin
                r_pend_valid <= 1'b0;
            end

            if (w_load) begin
                r_cmd_count <= r_cmd_count + 32'd1;
            end

            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign Fifo_ReadEn_out = w_pop;
    assign Valid_out       = (r_state == ST_PLAY);
    assign Sample_out      = (r_state == ST_PLAY) ? r_sample : '0;
    assign Busy_out        = (r_state == ST_PLAY) || r_pend_valid || r_inflight;
    assign Underflow_out   = r_underflow;
    assign CmdCount_out    = r_cmd_count;

endmodule

// File: tb/tb_fifo_cmd_player.sv
// -----------------------------------------------------------------------------
// tb_fifo_cmd_player
//
// Directed bench for fifo_cmd_player with a small FIFO model that honours
// the one-cycle read latency. Outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_cmd_player;

    logic        clk = 1'b0;
    logic        clear_in;
    logic        run_in;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [15:0] sample_out;
    logic        valid_out;
    logic        busy_out;
    logic        underflow_out;
    logic [31:0] cmd_count;

    int checks = 0;
    int errors = 0;

    // FIFO model
    logic [31:0] fifo_mem [0:31];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rden && !fifo_empty) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always #5 clk = ~clk;

    fifo_cmd_player dut (
        .Clk             (clk),
        .Clear_in        (clear_in),
        .Run_in          (run_in),
        .Fifo_Data_in    (fifo_data),
        .Fifo_Empty_in   (fifo_empty),
        .Fifo_ReadEn_out (fifo_rden),
        .Sample_out      (sample_out),
        .Valid_out       (valid_out),
        .Busy_out        (busy_out),
        .Underflow_out   (underflow_out),
        .CmdCount_out    (cmd_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] cnt, input logic [15:0] smp);
        fifo_mem[wr_ptr] = {cnt, smp};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_play(input string tag, input logic [15:0] smp);
        check({tag, " valid"}, {63'd0, valid_out}, 64'd1);
        check({tag, " sample"}, {48'd0, sample_out}, {48'd0, smp});
    endtask

    // Reset between sections with Run low, then verify the cleared state.
    task automatic section_clear(input string tag);
        clear_in = 1'b1;
        run_in   = 1'b0;
        tick();
        check({tag, " clr cmd"}, {32'd0, cmd_count}, 64'd0);
        check({tag, " clr uf"}, {63'd0, underflow_out}, 64'd0);
        check({tag, " clr busy"}, {63'd0, busy_out}, 64'd0);
    endtask

    function automatic logic [15:0] gap_exp(input int i);
        if (i < 3) return 16'h000A;
        else if (i < 9) return 16'h000B;
        else return 16'h000C;
    endfunction

    int          base;
    int          seen;
    logic [15:0] got [0:3];

    initial begin
        clear_in = 1'b1;
        run_in   = 1'b1;
        push(16'd4, 16'h1234);

        // ---------------- Reset with FIFO non-empty ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst rden", {63'd0, fifo_rden}, 64'd0);
            check("rst valid", {63'd0, valid_out}, 64'd0);
            check("rst sample", {48'd0, sample_out}, 64'd0);
            check("rst busy", {63'd0, busy_out}, 64'd0);
            check("rst uf", {63'd0, underflow_out}, 64'd0);
            check("rst cmd", {32'd0, cmd_count}, 64'd0);
        end
        check("rst nopop", rd_ptr, 64'd0);
        $display("step reset: checks=%0d", checks);

        // ---------------- Single command ----------------
        clear_in = 1'b0;
        #1;
        check("single rden0", {63'd0, fifo_rden}, 64'd1);
        tick();
        check("single rden1", {63'd0, fifo_rden}, 64'd0);
        check("single v1", {63'd0, valid_out}, 64'd0);
        check("single busy1", {63'd0, busy_out}, 64'd1);
        tick();
        check("single v2", {63'd0, valid_out}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_play("single play", 16'h1234);
            check("single uf", {63'd0, underflow_out}, 64'd0);
        end
        tick();
        check("single end v", {63'd0, valid_out}, 64'd0);
        check("single end sample", {48'd0, sample_out}, 64'd0);
        check("single end uf", {63'd0, underflow_out}, 64'd1);
        check("single end cmd", {32'd0, cmd_count}, 64'd1);
        check("single end busy", {63'd0, busy_out}, 64'd0);
        check("single pops", rd_ptr, 64'd1);
        $display("step single: checks=%0d errors=%0d", checks, errors);

        // ---------------- Gapless sequence ----------------
        section_clear("gap");
        push(16'd2, 16'h000A);
        push(16'd5, 16'h000B);
        push(16'd3, 16'h000C);
        clear_in = 1'b0;
        run_in   = 1'b1;
        tick();
        tick();
        check("gap pre v", {63'd0, valid_out}, 64'd0);
        for (int i = 0; i < 13; i++) begin
            tick();
            check_play("gap play", gap_exp(i));
            check("gap uf", {63'd0, underflow_out}, 64'd0);
        end
        tick();
        check("gap end v", {63'd0, valid_out}, 64'd0);
        check("gap end uf", {63'd0, underflow_out}, 64'd1);
        check("gap end cmd", {32'd0, cmd_count}, 64'd3);
        $display("step gapless: checks=%0d errors=%0d", checks, errors);

        // ---------------- Short commands ----------------
        section_clear("short");
        for (int k = 1; k <= 4; k++) push(16'd0, 16'(k));
        clear_in = 1'b0;
        run_in   = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (seen < 4) check("short uf early", {63'd0, underflow_out}, 64'd0);
            if (valid_out && seen < 4) begin
                got[seen] = sample_out;
                seen++;
            end
        end
        check("short seen", seen, 64'd4);
        for (int k = 0; k < 4; k++) check("short order", {48'd0, got[k]}, 64'(k + 1));
        check("short uf", {63'd0, underflow_out}, 64'd1);
        check("short cmd", {32'd0, cmd_count}, 64'd4);
        $display("step short: checks=%0d errors=%0d", checks, errors);

        // ---------------- Pause ----------------
        section_clear("pause");
        base = rd_ptr;
        push(16'd6, 16'h0055);
        push(16'd1, 16'h0066);
        push(16'd0, 16'h0088);
        clear_in = 1'b0;
        run_in   = 1'b1;
        tick();
        tick();
        tick();
        check_play("pause c1", 16'h0055);
        tick();
        check_play("pause c2", 16'h0055);
        run_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_play("pause hold", 16'h0055);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause v", {63'd0, valid_out}, 64'd0);
            check("pause busy", {63'd0, busy_out}, 64'd1);
            check("pause uf", {63'd0, underflow_out}, 64'd0);
            check("pause rden", {63'd0, fifo_rden}, 64'd0);
        end
        check("pause pops", rd_ptr - base, 64'd2);
        check("pause cmd", {32'd0, cmd_count}, 64'd1);
        run_in = 1'b1;
        tick();
        check_play("resume 66a", 16'h0066);
        tick();
        check_play("resume 66b", 16'h0066);
        tick();
        check_play("resume 88", 16'h0088);
        tick();
        check("resume end v", {63'd0, valid_out}, 64'd0);
        check("resume end uf", {63'd0, underflow_out}, 64'd1);
        check("resume end cmd", {32'd0, cmd_count}, 64'd3);
        $display("step pause: checks=%0d errors=%0d", checks, errors);

        // ---------------- Mid-command reset ----------------
        section_clear("midrst");
        push(16'd9, 16'h0077);
        push(16'd2, 16'h0099);
        clear_in = 1'b0;
        run_in   = 1'b1;
        tick();
        tick();
        tick();
        check_play("midrst c1", 16'h0077);
        tick();
        tick();
        check_play("midrst c3", 16'h0077);
        check("midrst busy", {63'd0, busy_out}, 64'd1);
        clear_in = 1'b1;
        #1;
        check("midrst rden", {63'd0, fifo_rden}, 64'd0);
        tick();
        check("midrst v", {63'd0, valid_out}, 64'd0);
        check("midrst sample", {48'd0, sample_out}, 64'd0);
        check("midrst busy0", {63'd0, busy_out}, 64'd0);
        check("midrst cmd", {32'd0, cmd_count}, 64'd0);
        check("midrst uf", {63'd0, underflow_out}, 64'd0);
        clear_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst after v", {63'd0, valid_out}, 64'd0);
            check("midrst after busy", {63'd0, busy_out}, 64'd0);
            check("midrst after cmd", {32'd0, cmd_count}, 64'd0);
        end
        $display("step midrst: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
